// File: rtl/ir_trip_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// ir_pkg
// Shared types and widths for the IR beam-break trip conditioner.
//   ir_state_t   : qualification FSM states
//   REV_W        : width of the wrapping revolution counter
//   GLITCH_W     : width of the saturating glitch counter
//   sat_inc_glitch() : saturating increment for the glitch counter
// -----------------------------------------------------------------------------
package ir_pkg;

   localparam int REV_W    = 16;
   localparam int GLITCH_W = 8;

   typedef enum logic [2:0] {
      IDLE,     // beam clear, waiting for a broken level
      QUAL_HI,  // beam broken, debouncing the leading edge
      ACTIVE,   // trip accepted, ir_tripped high
      QUAL_LO,  // beam clear again, debouncing the trailing edge
      REJECT    // debounced pulse arrived inside lockout, wait for release
   } ir_state_t;

   function automatic logic [GLITCH_W-1:0] sat_inc_glitch(input logic [GLITCH_W-1:0] v);
      return (v == {GLITCH_W{1'b1}}) ? v : v + GLITCH_W'(1);
   endfunction

endpackage

// File: rtl/ir_trip_conditioner_if.sv
// -----------------------------------------------------------------------------
// ir_trip_conditioner_if
// Bundles the raw sensor pin and the conditioned outputs.
//   ir_raw       : raw asynchronous sensor pin (into the conditioner)
//   ir_tripped   : debounced, qualified tripped level
//   trip_pulse   : one-cycle pulse per accepted trip
//   rev_count    : accepted trips, wrapping
//   glitch_count : rejected pulses, saturating
//   stalled      : no accepted trip for the stall window
// slave  : the conditioner side (reads ir_raw, drives the rest)
// master : the sensor / consumer side
// -----------------------------------------------------------------------------
interface ir_trip_conditioner_if;

   logic                        ir_raw;
   logic                        ir_tripped;
   logic                        trip_pulse;
   logic [ir_pkg::REV_W-1:0]    rev_count;
   logic [ir_pkg::GLITCH_W-1:0] glitch_count;
   logic                        stalled;

   modport master (
      output ir_raw,
      input  ir_tripped, trip_pulse, rev_count, glitch_count, stalled
   );

   modport slave (
      input  ir_raw,
      output ir_tripped, trip_pulse, rev_count, glitch_count, stalled
   );

endinterface

// File: rtl/ir_trip_conditioner_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// N-stage single-bit synchronizer with a programmable asynchronous reset value.
//   clk_in : destination clock
//   rst_in : asynchronous, active-high reset (loads RESET_VAL into every stage)
//   d      : asynchronous input
//   q      : synchronized output, STAGES cycles after d is first sampled
// -----------------------------------------------------------------------------
module sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // NOTE: non-blocking assignments make every stage sample the previous
   // stage's old value, giving a real shift chain rather than one flop.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) chain <= {STAGES{RESET_VAL}};
      else        chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/ir_trip_conditioner.sv
// -----------------------------------------------------------------------------
// ir_trip_conditioner
// Turns the raw IR beam-break pin into a clean, clock-synchronous tripped level
// for the rotation-angle tracker: synchronizes, debounces both edges, rejects
// trips faster than one physical revolution, and keeps debug counters.
//   clk_in : system clock
//   rst_in : asynchronous, active-high reset
//   bus    : ir_trip_conditioner_if.slave (ir_raw in; ir_tripped, trip_pulse,
//            rev_count, glitch_count, stalled out -- all direct flop outputs)
// -----------------------------------------------------------------------------
module ir_trip_conditioner
   import ir_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 1000,
   parameter int   LOCKOUT_CYCLES  = 2000000,
   parameter int   STALL_CYCLES    = 100000000,
   parameter logic ACTIVE_LEVEL    = 1'b1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   ir_trip_conditioner_if.slave  bus
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LO_W = $clog2(LOCKOUT_CYCLES + 1);
   localparam int ST_W = $clog2(STALL_CYCLES + 1);

   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [LO_W-1:0] LO_MAX = LO_W'(LOCKOUT_CYCLES);
   localparam logic [ST_W-1:0] ST_MAX = ST_W'(STALL_CYCLES);
   // stalled is registered, so it is set on the edge where the counter
   // steps from STALL_CYCLES-1 to STALL_CYCLES.
   localparam logic [ST_W-1:0] ST_SET = ST_W'(STALL_CYCLES - 1);

   ir_state_t       state;
   logic [DB_W-1:0] db_cnt;
   logic [LO_W-1:0] lock_cnt;
   logic [ST_W-1:0] stall_cnt;
   logic            sync_q;
   logic            s_in;

   // Reset to the inactive pin level so reset never looks like a broken beam.
   sync_ff #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (~ACTIVE_LEVEL)
   ) u_sync (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .d      (bus.ir_raw),
      .q      (sync_q)
   );

   // 1 = beam broken, independent of sensor polarity.
   assign s_in = sync_q ~^ ACTIVE_LEVEL;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state            <= IDLE;
         db_cnt           <= '0;
         lock_cnt         <= LO_MAX;   // first trip after reset is never locked out
         stall_cnt        <= '0;
         bus.ir_tripped   <= 1'b0;
         bus.trip_pulse   <= 1'b0;
         bus.rev_count    <= '0;
         bus.glitch_count <= '0;
         bus.stalled      <= 1'b0;
      end else begin
         bus.trip_pulse <= 1'b0;

         // Free-running saturating timers; an accepted trip below overrides them.
         if (lock_cnt != LO_MAX)  lock_cnt  <= lock_cnt + LO_W'(1);
         if (stall_cnt != ST_MAX) stall_cnt <= stall_cnt + ST_W'(1);
         if (stall_cnt >= ST_SET) bus.stalled <= 1'b1;

         case (state)
            IDLE: begin
               if (s_in) begin
                  state  <= QUAL_HI;
                  db_cnt <= DB_W'(1);
               end
            end

            QUAL_HI: begin
               if (!s_in) begin
                  state            <= IDLE;
                  bus.glitch_count <= sat_inc_glitch(bus.glitch_count);
               end else if (db_cnt == DB_MAX) begin
                  if (lock_cnt >= LO_MAX) begin
                     state          <= ACTIVE;
                     bus.ir_tripped <= 1'b1;
                     bus.trip_pulse <= 1'b1;
                     bus.rev_count  <= bus.rev_count + REV_W'(1);
                     lock_cnt       <= '0;   // lockout measured from acceptance
                     stall_cnt      <= '0;
                     bus.stalled    <= 1'b0; // acceptance beats stall saturation
                  end else begin
                     state            <= REJECT;
                     db_cnt           <= '0;
                     bus.glitch_count <= sat_inc_glitch(bus.glitch_count);
                  end
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end

            ACTIVE: begin
               if (!s_in) begin
                  state  <= QUAL_LO;
                  db_cnt <= DB_W'(1);
               end
            end

            QUAL_LO: begin
               if (s_in) begin
                  state <= ACTIVE;   // release bounce, same trip
               end else if (db_cnt == DB_MAX) begin
                  state          <= IDLE;
                  bus.ir_tripped <= 1'b0;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end

            REJECT: begin
               // Entered with db_cnt=0 while broken; the first clear cycle makes
               // it 1, matching the QUAL_LO release timing.
               if (s_in) begin
                  db_cnt <= '0;
               end else if (db_cnt == DB_MAX) begin
                  state <= IDLE;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
